// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and dataMemory signal bundle for data_mem_arbiter
interface data_mem_arbiter_if #(
    parameter int WORDSIZE  = 32,
    parameter int ADDR_BITS = 5
);
    logic                 r0_req;
    logic                 r0_we;
    logic [WORDSIZE-1:0]  r0_addr;
    logic [WORDSIZE-1:0]  r0_wdata;
    logic                 r0_gnt;
    logic                 r0_rvalid;
    logic                 r0_err;

    logic                 r1_req;
    logic                 r1_we;
    logic [WORDSIZE-1:0]  r1_addr;
    logic [WORDSIZE-1:0]  r1_wdata;
    logic                 r1_gnt;
    logic                 r1_rvalid;
    logic                 r1_err;

    logic [WORDSIZE-1:0]  rdata;
    logic                 mem_read;
    logic                 mem_write;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [WORDSIZE-1:0]  mem_wdata;
    logic [WORDSIZE-1:0]  mem_rdata;
    logic                 busy;

    // Arbiter side: takes requests and memory read data, drives grants and strobes
    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_gnt, r0_rvalid, r0_err,
        output r1_gnt, r1_rvalid, r1_err,
        output rdata, mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    // Requesters plus dataMemory side
    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_gnt, r0_rvalid, r0_err,
        input  r1_gnt, r1_rvalid, r1_err,
        input  rdata, mem_read, mem_write, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-port arbiter sequencing fixed-latency dataMemory reads
module data_mem_arbiter #(
    parameter int WORDSIZE    = 32,
    parameter int ADDR_BITS   = 5,
    parameter int MEM_LATENCY = 1
) (
    input logic clk,
    input logic reset,
    data_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 last_grant_q;
    logic                 rd_port_q;
    logic [1:0]           rvalid_q;
    logic [1:0]           err_q;
    logic [WORDSIZE-1:0]  rdata_q;

    logic                 grant;
    logic                 sel;
    logic                 sel_we;
    logic [WORDSIZE-1:0]  sel_addr;
    logic [WORDSIZE-1:0]  sel_wdata;
    logic                 illegal;

    // Pick the winner: a lone requester wins, a tie goes to the port not granted last
    always_comb begin
        sel       = (bus.r0_req && bus.r1_req) ? ~last_grant_q : bus.r1_req;
        grant     = (state_q == ST_IDLE) && (bus.r0_req || bus.r1_req);
        sel_we    = sel ? bus.r1_we    : bus.r0_we;
        sel_addr  = sel ? bus.r1_addr  : bus.r0_addr;
        sel_wdata = sel ? bus.r1_wdata : bus.r0_wdata;
        // Misaligned or beyond the memory depth: granted but never reaches dataMemory
        illegal   = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (ADDR_BITS + 2)) != '0);
    end

    // Grant-cycle outputs are combinational; everything is held at zero while in reset
    assign bus.r0_gnt    = reset && grant && !sel;
    assign bus.r1_gnt    = reset && grant &&  sel;
    assign bus.mem_read  = reset && grant && !illegal && !sel_we;
    assign bus.mem_write = reset && grant && !illegal &&  sel_we;
    assign bus.mem_addr  = (reset && grant) ? sel_addr[ADDR_BITS+1:2] : '0;
    assign bus.mem_wdata = (reset && grant) ? sel_wdata : '0;
    assign bus.r0_rvalid = reset && rvalid_q[0];
    assign bus.r1_rvalid = reset && rvalid_q[1];
    assign bus.r0_err    = reset && err_q[0];
    assign bus.r1_err    = reset && err_q[1];
    assign bus.rdata     = reset ? rdata_q : '0;
    assign bus.busy      = reset && (state_q == ST_WAIT);

    // IDLE/WAIT sequencer: record grants, flag errors, count down the read latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            rd_port_q    <= 1'b0;
            rvalid_q     <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
        end else begin
            rvalid_q <= '0;
            err_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        last_grant_q <= sel;
                        if (illegal) begin
                            err_q[sel] <= 1'b1;
                        end else if (!sel_we) begin
                            state_q   <= ST_WAIT;
                            cnt_q     <= CW'(MEM_LATENCY);
                            rd_port_q <= sel;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    // Last latency cycle: mem_rdata is valid now, return it next cycle
                    if (cnt_q == CW'(1)) begin
                        rdata_q             <= bus.mem_rdata;
                        rvalid_q[rd_port_q] <= 1'b1;
                        state_q             <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
    localparam int WS = 32;
    localparam int AB = 5;
    localparam int ML = 2;

    logic clk;
    logic reset;

    data_mem_arbiter_if #(.WORDSIZE(WS), .ADDR_BITS(AB)) bus ();

    data_mem_arbiter #(.WORDSIZE(WS), .ADDR_BITS(AB), .MEM_LATENCY(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // dataMemory model: writes on the edge, read address captured at the strobe
    logic [WS-1:0] mem [0:(1<<AB)-1];
    logic [AB-1:0] rd_a;
    assign bus.mem_rdata = mem[rd_a];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  rd_a <= bus.mem_addr;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic req0(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.r0_req = r; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    endtask

    task automatic req1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.r1_req = r; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = '0;
        rd_a  = '0;
        reset = 1'b0;
        req0(1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
        req1(1'b0, 1'b0, 32'h0, 32'h0);

        // 1: held in reset with r0 requesting -> everything quiet
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            settle();
            chk("rst_r0_gnt", {31'b0, bus.r0_gnt}, 32'd0);
            chk("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
            chk("rst_busy", {31'b0, bus.busy}, 32'd0);
            chk("rst_rdata", bus.rdata, 32'd0);
            chk("rst_mem_addr", {27'b0, bus.mem_addr}, 32'd0);
        end
        tick();
        reset = 1'b1;
        settle();
        // 2: first cycle after release grants r0's write
        chk("t2_r0_gnt", {31'b0, bus.r0_gnt}, 32'd1);
        chk("t2_mem_write", {31'b0, bus.mem_write}, 32'd1);
        chk("t2_mem_addr", {27'b0, bus.mem_addr}, 32'd2);
        chk("t2_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        tick();
        req0(1'b0, 1'b0, 32'h0, 32'h0);
        req1(1'b1, 1'b0, 32'h8, 32'h0);
        settle();
        chk("t2_r1_gnt", {31'b0, bus.r1_gnt}, 32'd1);
        chk("t2_mem_read", {31'b0, bus.mem_read}, 32'd1);
        tick();
        req1(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("t2_busy1", {31'b0, bus.busy}, 32'd1);
        chk("t2_rvalid_early", {31'b0, bus.r1_rvalid}, 32'd0);
        tick();
        settle();
        chk("t2_busy2", {31'b0, bus.busy}, 32'd1);
        tick();
        settle();
        chk("t2_r1_rvalid", {31'b0, bus.r1_rvalid}, 32'd1);
        chk("t2_rdata", bus.rdata, 32'hDEADBEEF);
        chk("t2_busy3", {31'b0, bus.busy}, 32'd0);

        // 3: both writing continuously -> 0,1,0,1
        tick();
        req0(1'b1, 1'b1, 32'h10, 32'h11111111);
        req1(1'b1, 1'b1, 32'h14, 32'h22222222);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            settle();
            chk("t3_r0_gnt", {31'b0, bus.r0_gnt}, (c % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_r1_gnt", {31'b0, bus.r1_gnt}, (c % 2 == 1) ? 32'd1 : 32'd0);
            chk("t3_mem_addr", {27'b0, bus.mem_addr}, (c % 2 == 0) ? 32'd4 : 32'd5);
            chk("t3_mem_write", {31'b0, bus.mem_write}, 32'd1);
        end

        // 4: r0 read blocks r1 write until the read data returns
        tick();
        req0(1'b1, 1'b0, 32'h14, 32'h0);
        req1(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("t4_r0_gnt", {31'b0, bus.r0_gnt}, 32'd1);
        tick();
        req0(1'b0, 1'b0, 32'h0, 32'h0);
        req1(1'b1, 1'b1, 32'h18, 32'h33333333);
        settle();
        chk("t4_busy1", {31'b0, bus.busy}, 32'd1);
        chk("t4_r1_gnt1", {31'b0, bus.r1_gnt}, 32'd0);
        chk("t4_mem_write1", {31'b0, bus.mem_write}, 32'd0);
        tick();
        settle();
        chk("t4_busy2", {31'b0, bus.busy}, 32'd1);
        chk("t4_r1_gnt2", {31'b0, bus.r1_gnt}, 32'd0);
        tick();
        settle();
        chk("t4_r1_gnt3", {31'b0, bus.r1_gnt}, 32'd1);
        chk("t4_r0_rvalid", {31'b0, bus.r0_rvalid}, 32'd1);
        chk("t4_rdata", bus.rdata, 32'h22222222);
        chk("t4_mem_write3", {31'b0, bus.mem_write}, 32'd1);
        chk("t4_busy3", {31'b0, bus.busy}, 32'd0);

        // 5: illegal accesses are granted without any strobe, then flagged
        tick();
        req1(1'b0, 1'b0, 32'h0, 32'h0);
        req0(1'b1, 1'b0, 32'h6, 32'h0);
        settle();
        chk("t5_r0_gnt", {31'b0, bus.r0_gnt}, 32'd1);
        chk("t5_mem_read", {31'b0, bus.mem_read}, 32'd0);
        tick();
        req0(1'b0, 1'b0, 32'h0, 32'h0);
        req1(1'b1, 1'b1, 32'h80, 32'h44444444);
        settle();
        chk("t5_r0_err", {31'b0, bus.r0_err}, 32'd1);
        chk("t5_busy", {31'b0, bus.busy}, 32'd0);
        chk("t5_r1_gnt", {31'b0, bus.r1_gnt}, 32'd1);
        chk("t5_mem_write", {31'b0, bus.mem_write}, 32'd0);
        tick();
        req1(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("t5_r1_err", {31'b0, bus.r1_err}, 32'd1);
        chk("t5_r0_err_clr", {31'b0, bus.r0_err}, 32'd0);

        // 6: reset mid-read abandons it; tie afterwards goes to r0
        tick();
        req0(1'b1, 1'b0, 32'h8, 32'h0);
        settle();
        chk("t6_r0_gnt", {31'b0, bus.r0_gnt}, 32'd1);
        chk("t6_mem_read", {31'b0, bus.mem_read}, 32'd1);
        tick();
        req0(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        settle();
        chk("t6_busy_rst", {31'b0, bus.busy}, 32'd0);
        tick();
        reset = 1'b1;
        req0(1'b1, 1'b1, 32'h1C, 32'h55555555);
        req1(1'b1, 1'b1, 32'h0C, 32'h66666666);
        settle();
        chk("t6_r0_gnt2", {31'b0, bus.r0_gnt}, 32'd1);
        chk("t6_r1_gnt2", {31'b0, bus.r1_gnt}, 32'd0);
        chk("t6_rvalid_a", {31'b0, bus.r0_rvalid}, 32'd0);
        tick();
        req0(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("t6_r1_gnt3", {31'b0, bus.r1_gnt}, 32'd1);
        chk("t6_rvalid_b", {31'b0, bus.r0_rvalid}, 32'd0);
        tick();
        req1(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("t6_rvalid_c", {31'b0, bus.r0_rvalid}, 32'd0);
        chk("t6_idle_gnt", {30'b0, bus.r1_gnt, bus.r0_gnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
